// File: rtl/codec_pulse_multi_synchronizer.sv
// codec_pulse_multi_synchronizer
// Lossless multi-channel pulse synchronizer from the clkin domain to the clkout domain.
// Each channel counts its input pulses in a saturating accumulator and hands the
// accumulated count across with a toggle req/ack handshake. The clkout side emits one
// strobe per completed transfer together with the number of pulses it represents.
// The hold register only changes at launch, so it is stable for the whole time the
// clkout side may sample it and needs no per-bit synchronization.
`timescale 1ns/1ps
module codec_pulse_multi_synchronizer #(
    parameter int pN     = 4,
    parameter int pSYNC  = 2,
    parameter int pCNT_W = 4
) (
    input  logic                 clkin,
    input  logic                 resetin,
    input  logic                 clkout,
    input  logic                 resetout,
    input  logic [pN-1:0]        sin,
    output logic [pN-1:0]        busy,
    output logic [pN-1:0]        ovf,
    output logic [pN-1:0]        sout,
    output logic [pN*pCNT_W-1:0] sout_num
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [pCNT_W-1:0] CNT_MAX = {pCNT_W{1'b1}};
    localparam logic [pCNT_W-1:0] CNT_ONE = pCNT_W'(1);

    genvar ch;
    generate
        for (ch = 0; ch < pN; ch++) begin : g_ch

            state_t            state;
            logic [pCNT_W-1:0] acc;
            logic [pCNT_W-1:0] hold;
            logic              req_t;
            logic              ovf_r;
            logic [pSYNC-1:0]  ack_s;

            logic [pSYNC-1:0]  req_s;
            logic              req_d;
            logic              ack_t;
            logic              sout_r;
            logic [pCNT_W-1:0] num_r;

            // Bring the returning ack toggle into the clkin domain.
            always_ff @(posedge clkin or posedge resetin) begin
                if (resetin) begin
                    ack_s <= '0;
                end else begin
                    ack_s <= {ack_s[pSYNC-2:0], ack_t};
                end
            end

            // Source-side FSM: accumulate pulses, launch a transfer when idle with a
            // non-zero count, keep counting (saturating) while the transfer is in flight.
            always_ff @(posedge clkin or posedge resetin) begin
                if (resetin) begin
                    state <= IDLE;
                    acc   <= '0;
                    hold  <= '0;
                    req_t <= 1'b0;
                    ovf_r <= 1'b0;
                end else begin
                    ovf_r <= 1'b0;
                    case (state)
                        IDLE: begin
                            if (acc != '0) begin
                                hold  <= acc;
                                acc   <= pCNT_W'(sin[ch]);
                                req_t <= ~req_t;
                                state <= WAIT;
                            end else begin
                                acc <= pCNT_W'(sin[ch]);
                            end
                        end
                        WAIT: begin
                            if (sin[ch]) begin
                                if (acc == CNT_MAX) begin
                                    ovf_r <= 1'b1;
                                end else begin
                                    acc <= acc + CNT_ONE;
                                end
                            end
                            if (ack_s[pSYNC-1] == req_t) begin
                                state <= IDLE;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end

            // Destination side: synchronize req, detect its toggle, capture the held
            // count, strobe sout for one cycle and echo the toggle back as ack.
            always_ff @(posedge clkout or posedge resetout) begin
                if (resetout) begin
                    req_s  <= '0;
                    req_d  <= 1'b0;
                    ack_t  <= 1'b0;
                    sout_r <= 1'b0;
                    num_r  <= '0;
                end else begin
                    req_s  <= {req_s[pSYNC-2:0], req_t};
                    req_d  <= req_s[pSYNC-1];
                    sout_r <= 1'b0;
                    if (req_s[pSYNC-1] != req_d) begin
                        num_r  <= hold;
                        sout_r <= 1'b1;
                        ack_t  <= req_s[pSYNC-1];
                    end
                end
            end

            assign busy[ch]                        = (state == WAIT);
            assign ovf[ch]                         = ovf_r;
            assign sout[ch]                        = sout_r;
            assign sout_num[ch*pCNT_W +: pCNT_W]   = num_r;

        end
    endgenerate

endmodule

// File: tb/tb_codec_pulse_multi_synchronizer.sv
// tb_codec_pulse_multi_synchronizer
// Directed and randomized checks of the multi-channel pulse synchronizer. The reference
// model counts the pulses driven per channel and predicts strobe counts, strobe values
// and overflow totals from the pulse-conservation rule and the saturation limit.
`timescale 1ns/1ps
module tb_codec_pulse_multi_synchronizer;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int LOGD = 2048;

    logic          clkin  = 1'b0;
    logic          clkout = 1'b0;
    logic          resetin;
    logic          resetout;
    logic [N-1:0]  sin;
    logic [N-1:0]  busy;
    logic [N-1:0]  ovf;
    logic [N-1:0]  sout;
    logic [N*CW-1:0] sout_num;

    real in_half  = 5.0;
    real out_half = 13.5;

    int total = 0;
    int bad   = 0;

    int strobe_cnt [N];
    int strobe_sum [N];
    int ovf_cnt    [N];
    int strobe_log [N][LOGD];

    int pulses [N];
    int b_cnt  [N];
    int b_sum  [N];
    int b_ovf  [N];
    int b_pul  [N];

    codec_pulse_multi_synchronizer #(
        .pN     (N),
        .pSYNC  (SYNC),
        .pCNT_W (CW)
    ) dut (
        .clkin    (clkin),
        .resetin  (resetin),
        .clkout   (clkout),
        .resetout (resetout),
        .sin      (sin),
        .busy     (busy),
        .ovf      (ovf),
        .sout     (sout),
        .sout_num (sout_num)
    );

    // Source and destination clocks with run-time adjustable periods.
    always #(in_half) clkin = ~clkin;

    // Destination clock.
    always #(out_half) clkout = ~clkout;

    // Log every completed transfer seen on the destination side.
    always @(negedge clkout) begin
        for (int c = 0; c < N; c++) begin
            if (sout[c]) begin
                if (strobe_cnt[c] < LOGD) begin
                    strobe_log[c][strobe_cnt[c]] <= int'(sout_num[c*CW +: CW]);
                end
                strobe_cnt[c] <= strobe_cnt[c] + 1;
                strobe_sum[c] <= strobe_sum[c] + int'(sout_num[c*CW +: CW]);
            end
        end
    end

    // Count overflow strobes on the source side.
    always @(negedge clkin) begin
        for (int c = 0; c < N; c++) begin
            if (ovf[c]) begin
                ovf_cnt[c] <= ovf_cnt[c] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snapshot();
        for (int c = 0; c < N; c++) begin
            b_cnt[c] = strobe_cnt[c];
            b_sum[c] = strobe_sum[c];
            b_ovf[c] = ovf_cnt[c];
            b_pul[c] = pulses[c];
        end
    endtask

    function automatic int d_cnt(input int c);
        return strobe_cnt[c] - b_cnt[c];
    endfunction

    function automatic int d_sum(input int c);
        return strobe_sum[c] - b_sum[c];
    endfunction

    function automatic int d_ovf(input int c);
        return ovf_cnt[c] - b_ovf[c];
    endfunction

    function automatic int d_pul(input int c);
        return pulses[c] - b_pul[c];
    endfunction

    function automatic int log_at(input int c, input int k);
        int idx;
        idx = b_cnt[c] + k;
        if (idx < LOGD) return strobe_log[c][idx];
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] pat);
        sin = pat;
        for (int c = 0; c < N; c++) begin
            if (pat[c]) pulses[c]++;
        end
        @(negedge clkin);
    endtask

    task automatic wait_busy(input int c, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clkin);
            if (busy[c]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(output bit ok);
        int quiet;
        quiet = 0;
        ok    = 1'b0;
        sin   = '0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clkin);
            if (busy == '0) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clkout);
        @(negedge clkin);
    endtask

    task automatic check_conservation(input string tag);
        for (int c = 0; c < N; c++) begin
            check($sformatf("%s_ch%0d", tag, c), d_sum(c) + d_ovf(c), d_pul(c));
        end
    endtask

    initial begin
        bit ok;
        bit seen;
        int bad_vals;
        logic [N-1:0] pat;

        resetin  = 1'b1;
        resetout = 1'b1;
        sin      = '0;
        repeat (3) @(negedge clkin);
        repeat (2) @(negedge clkout);
        check("reset_busy",     busy,     0);
        check("reset_ovf",      ovf,      0);
        check("reset_sout",     sout,     0);
        check("reset_sout_num", sout_num, 0);
        resetin  = 1'b0;
        resetout = 1'b0;
        repeat (4) @(negedge clkin);

        $display("[TB] single pulse on ch2");
        snapshot();
        drive(4'b0100);
        drive(4'b0000);
        wait_busy(2, seen);
        check("single_busy_rise", seen, 1);
        drain(ok);
        check("single_drain", ok, 1);
        check("single_busy_fall", busy[2], 0);
        check("single_strobes", d_cnt(2), 1);
        check("single_num", log_at(2, 0), 1);
        check("single_ovf", d_ovf(2), 0);
        check("single_other_ch0", d_cnt(0), 0);

        $display("[TB] burst during transfer on ch0");
        snapshot();
        drive(4'b0001);
        drive(4'b0000);
        wait_busy(0, seen);
        check("burst_busy_rise", seen, 1);
        repeat (5) drive(4'b0001);
        drain(ok);
        check("burst_drain", ok, 1);
        check("burst_strobes", d_cnt(0), 2);
        check("burst_first", log_at(0, 0), 1);
        check("burst_second", log_at(0, 1), 5);
        check("burst_ovf", d_ovf(0), 0);

        $display("[TB] saturation with slow destination clock");
        out_half = 100.0;
        repeat (3) @(negedge clkout);
        @(negedge clkin);
        snapshot();
        drive(4'b0001);
        drive(4'b0000);
        wait_busy(0, seen);
        check("sat_busy_rise", seen, 1);
        repeat (CMAX + 3) drive(4'b0001);
        drain(ok);
        check("sat_drain", ok, 1);
        check("sat_strobes", d_cnt(0), 2);
        check("sat_first", log_at(0, 0), 1);
        check("sat_second", log_at(0, 1), CMAX);
        check("sat_ovf", d_ovf(0), 3);
        out_half = 13.5;
        repeat (3) @(negedge clkout);
        @(negedge clkin);

        $display("[TB] continuous input, fast source clock");
        snapshot();
        repeat (1000) drive('1);
        drain(ok);
        check("cont_fast_drain", ok, 1);
        check_conservation("cont_fast");
        check("cont_fast_total_ch3", d_pul(3), 1000);

        $display("[TB] continuous input, slow source clock");
        in_half  = 13.5;
        out_half = 5.0;
        repeat (3) @(negedge clkin);
        snapshot();
        repeat (1000) drive('1);
        drain(ok);
        check("cont_slow_drain", ok, 1);
        check_conservation("cont_slow");
        in_half  = 5.0;
        out_half = 13.5;
        repeat (3) @(negedge clkin);

        $display("[TB] random distinct patterns on all channels");
        snapshot();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) begin
                pat[c] = (($urandom % 100) < (c + 1) * 20);
            end
            drive(pat);
        end
        drain(ok);
        check("rand_drain", ok, 1);
        check_conservation("rand");
        for (int c = 0; c < N; c++) begin
            bad_vals = 0;
            for (int k = 0; k < d_cnt(c); k++) begin
                if (log_at(c, k) < 1 || log_at(c, k) > CMAX) bad_vals++;
            end
            check($sformatf("rand_range_ch%0d", c), bad_vals, 0);
        end

        $display("[TB] both resets mid-transfer");
        drive('1);
        drive('0);
        wait_busy(0, seen);
        check("rst_busy_rise", seen, 1);
        drive('1);
        resetin  = 1'b1;
        resetout = 1'b1;
        sin      = '0;
        repeat (3) @(negedge clkin);
        check("rst_busy",     busy,     0);
        check("rst_ovf",      ovf,      0);
        check("rst_sout",     sout,     0);
        check("rst_sout_num", sout_num, 0);
        resetin  = 1'b0;
        resetout = 1'b0;
        repeat (5) @(negedge clkin);
        snapshot();
        drive(4'b0010);
        drive(4'b0000);
        drain(ok);
        check("rst_drain", ok, 1);
        check("rst_strobes", d_cnt(1), 1);
        check("rst_num", log_at(1, 0), 1);
        check("rst_other_ch0", d_cnt(0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
